// File: rtl/ws2812_rx_pkg.sv
// Shared WS2812 timing constants (12 MHz), receiver state encoding and GRB field layout.
// Used by the receiver and by any transmitter/test code that needs the same byte order.
package ws2812_rx_pkg;

  localparam int T_THRESH_CYC_12M = 7;
  localparam int T_GLITCH_CYC_12M = 2;
  localparam int T_HMAX_CYC_12M   = 24;
  localparam int T_RESET_CYC_12M  = 600;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  function automatic logic [23:0] grb_pack(input logic [7:0] g, input logic [7:0] r,
                                           input logic [7:0] b);
    logic [23:0] p;
    p = '0;
    p[G_LSB +: 8] = g;
    p[R_LSB +: 8] = r;
    p[B_LSB +: 8] = b;
    return p;
  endfunction

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoded pixel stream and frame events from the WS2812 receiver.
// No backpressure: the consumer must take every o_valid pulse.
interface ws2812_rx_if;
  logic [23:0] o_pixel;
  logic        o_valid;
  logic        o_latch;
  logic        o_err;
  logic [7:0]  o_pix_cnt;
  logic        o_busy;

  modport master (output o_pixel, o_valid, o_latch, o_err, o_pix_cnt, o_busy);
  modport slave  (input  o_pixel, o_valid, o_latch, o_err, o_pix_cnt, o_busy);
endinterface

// File: rtl/ws2812_rx_sync.sv
// 2-FF synchroniser for the async data line plus rise/fall pulses at the synchroniser output.
// Latency: 2 cycles to o_lvl; edges are combinational from o_lvl and its registered copy.
module ws2812_rx_sync (
  input  logic CLK,
  input  logic RSTN,
  input  logic i_din,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_lvl  = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: measures high pulses into bits, assembles GRB pixels, flags latch gap and errors.
// Pixel/valid register one cycle after the synchronised falling edge; no backpressure.
module ws2812_rx
  import ws2812_rx_pkg::*;
#(
  parameter int T_THRESH_CYC = T_THRESH_CYC_12M,
  parameter int T_GLITCH_CYC = T_GLITCH_CYC_12M,
  parameter int T_HMAX_CYC   = T_HMAX_CYC_12M,
  parameter int T_RESET_CYC  = T_RESET_CYC_12M
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          i_din,
  ws2812_rx_if.master   o_rx
);

  localparam int LO_W = $clog2(T_RESET_CYC + 1);
  localparam int HI_W = $clog2(T_HMAX_CYC + 2);

  logic w_lvl, w_rise, w_fall;

  ws2812_rx_sync u_sync (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .i_din  (i_din),
    .o_lvl  (w_lvl),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_t            r_state;
  logic [LO_W-1:0]   r_lo_cnt;
  logic [HI_W-1:0]   r_hi_cnt;
  logic [4:0]        r_bit_cnt;
  logic [23:0]       r_shreg;
  logic [23:0]       r_pixel;
  logic [7:0]        r_pix_cnt;
  logic              r_valid, r_latch, r_err, r_clr_pend;

  logic w_bit, w_lo_last, w_lo_full, w_frame;

  assign w_bit     = (r_hi_cnt >= HI_W'(T_THRESH_CYC));
  assign w_lo_last = (r_lo_cnt == LO_W'(T_RESET_CYC - 1));
  assign w_lo_full = (r_lo_cnt == LO_W'(T_RESET_CYC));
  assign w_frame   = (r_pix_cnt != 8'd0) || (r_bit_cnt != 5'd0);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_SYNC;
      r_lo_cnt   <= '0;
      r_hi_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_pixel    <= '0;
      r_pix_cnt  <= '0;
      r_valid    <= 1'b0;
      r_latch    <= 1'b0;
      r_err      <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_valid    <= 1'b0;
      r_latch    <= 1'b0;
      r_err      <= 1'b0;
      r_clr_pend <= 1'b0;
      // The latch pulse reports the final count; the clear lands one cycle later.
      if (r_clr_pend) r_pix_cnt <= '0;

      case (r_state)
        S_SYNC: begin
          if (w_lvl) begin
            r_lo_cnt <= '0;
          end else if (!w_lo_full) begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
            if (w_lo_last) r_state <= S_LOW;
          end
        end

        S_LOW: begin
          if (w_rise) begin
            r_state  <= S_HIGH;
            r_hi_cnt <= HI_W'(1);
          end else if (!w_lo_full) begin
            r_lo_cnt <= r_lo_cnt + 1'b1;
            if (w_lo_last) begin
              if (w_frame) begin
                r_latch    <= 1'b1;
                r_clr_pend <= 1'b1;
              end
              if (r_bit_cnt != 5'd0) begin
                r_err   <= 1'b1;
                r_shreg <= '0;
              end
              r_bit_cnt <= '0;
            end
          end
        end

        S_HIGH: begin
          if (r_hi_cnt > HI_W'(T_HMAX_CYC)) begin
            r_err     <= 1'b1;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_lo_cnt  <= '0;
            r_state   <= S_SYNC;
          end else if (w_fall) begin
            r_lo_cnt <= '0;
            r_state  <= S_LOW;
            // Pulses shorter than the glitch limit are dropped without touching bit state.
            if (r_hi_cnt >= HI_W'(T_GLITCH_CYC)) begin
              r_shreg <= {r_shreg[22:0], w_bit};
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= '0;
                r_pixel   <= {r_shreg[22:0], w_bit};
                r_valid   <= 1'b1;
                if (r_pix_cnt != 8'hFF) r_pix_cnt <= r_pix_cnt + 8'd1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end else if (r_hi_cnt != HI_W'(T_HMAX_CYC + 1)) begin
            r_hi_cnt <= r_hi_cnt + 1'b1;
          end
        end

        default: r_state <= S_SYNC;
      endcase
    end
  end

  assign o_rx.o_pixel   = r_pixel;
  assign o_rx.o_valid   = r_valid;
  assign o_rx.o_latch   = r_latch;
  assign o_rx.o_err     = r_err;
  assign o_rx.o_pix_cnt = r_pix_cnt;
  assign o_rx.o_busy    = (r_state != S_SYNC);

endmodule
